// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU sharing arbiter.
// ALU control codes match the ALUControl encoding.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: first set req bit
// scanning upward from last+1, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && (i == j) && req[i]) begin
          any       = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU among NUM_REQ requesters:
// round-robin accept, one EXEC cycle, registered response.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [4*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_zero,
  output logic [3:0]               alu_ctrl,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero
);

  localparam int IW = idx_w(NUM_REQ);

  state_t             state;
  state_t             state_nx;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               any;
  logic               take;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      owner;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req       (req_valid),
    .last      (last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign take      = (state == S_IDLE) && any;
  assign req_ready = (state == S_IDLE) ? grant : '0;

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand registers feed the ALU directly, so ALU inputs
  // only move on an accept and stay quiet otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      owner      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else if (take) begin
      op_q       <= sel_op;
      a_q        <= sel_a;
      b_q        <= sel_b;
      owner      <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (state == S_EXEC) begin
      res_q  <= alu_result;
      zero_q <= alu_zero;
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = (state == S_RESP) && (owner == IW'(i));
    end
  end

  assign alu_ctrl    = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural
// ALU hung off the shared ALU port.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic           resp_zero;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic           alu_zero;

  typedef struct {
    int         idx;
    logic [W-1:0] res;
    logic       zero;
  } exp_t;

  exp_t       sb[$];
  int         glog[$];
  int         acc_cyc[$];
  logic [W-1:0] exp_res [N];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         k;

  alu_share_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .alu_ctrl    (alu_ctrl),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    case (alu_ctrl)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{i, exp_res[i], exp_res[i] == '0});
          glog.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("unexp_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_route", 64'(resp_valid), 64'(1 << e.idx));
          chk("resp_result", 64'(resp_result), 64'(e.res));
          chk("resp_zero", 64'(resp_zero), 64'(e.zero));
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(int r, logic [3:0] op, logic [W-1:0] a,
                         logic [W-1:0] b, logic [W-1:0] exp);
    for (int i = 0; i < N; i++) begin
      if (i == r) begin
        req_op[4*i +: 4] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
        exp_res[i]       = exp;
        req_valid[i]     = 1'b1;
      end
    end
  endtask

  task automatic run_op(int r, logic [3:0] op, logic [W-1:0] a,
                        logic [W-1:0] b, logic [W-1:0] exp);
    int n;
    n = 0;
    set_req(r, op, a, b, exp);
    #1;
    while (!req_ready[r] && n < 10) begin
      tick(1);
      n++;
    end
    chk("grant_wait", 64'(n < 10), 64'd1);
    tick(1);
    req_valid = '0;
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) exp_res[i] = '0;
    tick(2);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_zero", 64'(resp_zero), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    reset = 1'b0;
    tick(1);

    // single ADD with explicit latency checks
    set_req(0, ALU_ADD, 32'd5, 32'd7, 32'd12);
    #2;
    chk("add_ready", 64'(req_ready), 64'd1);
    tick(1);
    req_valid = '0;
    chk("exec_ready", 64'(req_ready), 64'd0);
    chk("exec_alu_a", 64'(alu_a), 64'd5);
    chk("exec_resp_valid", 64'(resp_valid), 64'd0);
    tick(1);
    chk("resp_pulse", 64'(resp_valid), 64'd1);
    chk("resp_ready", 64'(req_ready), 64'd0);
    tick(1);
    chk("resp_end", 64'(resp_valid), 64'd0);
    chk("resp_hold", 64'(resp_result), 64'd12);
    tick(1);

    run_op(0, ALU_SUB, 32'd9, 32'd9, 32'd0);
    run_op(1, ALU_AND, 32'hF0, 32'h3C, 32'h30);
    run_op(0, ALU_OR, 32'hF0, 32'h0F, 32'hFF);

    // contention right after reset
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    glog.delete();
    acc_cyc.delete();
    set_req(0, ALU_ADD, 32'd100, 32'd1, 32'd101);
    set_req(1, ALU_SUB, 32'd50, 32'd8, 32'd42);
    k = 0;
    while (glog.size() < 4 && k < 20) begin
      tick(1);
      k++;
    end
    req_valid = '0;
    tick(4);
    chk("rr_count", 64'(glog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) chk("rr_order", 64'(glog[i]), 64'(i % 2));
    end

    // withdrawal of req1 during EXEC of req0
    glog.delete();
    set_req(0, ALU_OR, 32'd1, 32'd2, 32'd3);
    tick(1);
    req_valid = '0;
    set_req(1, ALU_ADD, 32'd3, 32'd3, 32'd6);
    #1;
    chk("wd_ready", 64'(req_ready), 64'd0);
    tick(1);
    req_valid = '0;
    tick(5);
    chk("wd_grants", 64'(glog.size()), 64'd1);
    if (glog.size() > 0) chk("wd_owner", 64'(glog[0]), 64'd0);

    // back-to-back with valid held
    glog.delete();
    acc_cyc.delete();
    set_req(0, ALU_SUB, 32'd20, 32'd5, 32'd15);
    k = 0;
    while (glog.size() < 3 && k < 15) begin
      tick(1);
      k++;
      if (glog.size() > 0 && (cyc - acc_cyc[$]) inside {1, 2})
        chk("b2b_ready_low", 64'(req_ready), 64'd0);
    end
    req_valid = '0;
    tick(4);
    chk("b2b_count", 64'(acc_cyc.size()), 64'd3);
    for (int i = 1; i < 3; i++) begin
      if (i < acc_cyc.size())
        chk("b2b_period", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
    end

    // reset while in EXEC
    set_req(0, ALU_ADD, 32'h1234, 32'd1, 32'h1235);
    tick(1);
    req_valid = '0;
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
    chk("mid_rst_alu_b", 64'(alu_b), 64'd0);
    chk("mid_rst_result", 64'(resp_result), 64'd0);
    chk("mid_rst_zero", 64'(resp_zero), 64'd0);
    sb.delete();
    tick(2);
    reset = 1'b0;
    tick(4);
    set_req(0, ALU_AND, 32'hF0, 32'h3C, 32'h30);
    set_req(1, ALU_OR, 32'hF0, 32'h0F, 32'hFF);
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'd1);
    tick(1);
    req_valid = '0;
    tick(4);

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
